// File: rtl/rv32_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rv32_alu_arbiter
// Brief    : Two-requester arbiter in front of a shared registered RV32 ALU.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_alu_arbiter #(
  parameter int PRIO_MODE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_s1,
  input  logic [31:0] req0_s2,
  input  logic [31:0] req0_pc,
  input  logic [31:0] req0_code,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_s1,
  input  logic [31:0] req1_s2,
  input  logic [31:0] req1_pc,
  input  logic [31:0] req1_code,
  output logic        alu_enable,
  output logic [3:0]  alu_opsel,
  output logic [31:0] alu_s1,
  output logic [31:0] alu_s2,
  output logic [31:0] alu_pc,
  output logic [31:0] alu_code,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  input  logic        flush
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_grant;
  logic        r_id;
  logic [3:0]  r_opsel;
  logic [31:0] r_s1;
  logic [31:0] r_s2;
  logic [31:0] r_pc;
  logic [31:0] r_code;

  logic        w_grant;
  logic        w_grant_id;
  logic [3:0]  w_sel_op;
  logic [31:0] w_sel_s1;
  logic [31:0] w_sel_s2;
  logic [31:0] w_sel_pc;
  logic [31:0] w_sel_code;

  // Contention goes to whoever was not granted last, unless fixed priority.
  always_comb begin
    w_grant_id = 1'b0;
    if (req0_valid && req1_valid)
      w_grant_id = (PRIO_MODE == 1) ? 1'b0 : ~r_last_grant;
    else if (req1_valid)
      w_grant_id = 1'b1;
  end

  // rst_n gates the readies so they are low for the whole reset window.
  assign w_grant    = rst_n && (r_state == ST_IDLE) && !flush && (req0_valid || req1_valid);
  assign req0_ready = w_grant && !w_grant_id;
  assign req1_ready = w_grant && w_grant_id;

  assign w_sel_op   = w_grant_id ? req1_op   : req0_op;
  assign w_sel_s1   = w_grant_id ? req1_s1   : req0_s1;
  assign w_sel_s2   = w_grant_id ? req1_s2   : req0_s2;
  assign w_sel_pc   = w_grant_id ? req1_pc   : req0_pc;
  assign w_sel_code = w_grant_id ? req1_code : req0_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_grant) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = flush ? ST_IDLE : ST_RESP;
      ST_RESP: if (flush || rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_opsel      <= 4'd0;
      r_s1         <= 32'd0;
      r_s2         <= 32'd0;
      r_pc         <= 32'd0;
      r_code       <= 32'd0;
    end else if (w_grant) begin
      r_last_grant <= w_grant_id;
      r_id         <= w_grant_id;
      r_opsel      <= w_sel_op;
      r_s1         <= w_sel_s1;
      r_s2         <= w_sel_s2;
      r_pc         <= w_sel_pc;
      r_code       <= w_sel_code;
    end
  end

  assign alu_enable = (r_state == ST_EXEC);
  assign alu_opsel  = r_opsel;
  assign alu_s1     = r_s1;
  assign alu_s2     = r_s2;
  assign alu_pc     = r_pc;
  assign alu_code   = r_code;

  // A flush in RESP withdraws the response in the same cycle.
  assign rsp_valid  = (r_state == ST_RESP) && !flush;
  assign rsp_id     = r_id;
  assign rsp_data   = alu_result;

endmodule
`default_nettype wire

// File: tb/tb_rv32_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_alu_arbiter
// Brief    : Directed self-checking bench for rv32_alu_arbiter (both modes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_s1, req0_s2, req0_pc, req0_code;
  logic [31:0] req1_s1, req1_s2, req1_pc, req1_code;
  logic        rsp_ready, flush;

  logic        rr_req0_ready, rr_req1_ready, rr_alu_enable, rr_rsp_valid, rr_rsp_id;
  logic [3:0]  rr_alu_opsel;
  logic [31:0] rr_alu_s1, rr_alu_s2, rr_alu_pc, rr_alu_code, rr_rsp_data;
  logic [31:0] rr_alu_result = 32'd0;

  logic        fp_req0_ready, fp_req1_ready, fp_alu_enable, fp_rsp_valid, fp_rsp_id;
  logic [3:0]  fp_alu_opsel;
  logic [31:0] fp_alu_s1, fp_alu_s2, fp_alu_pc, fp_alu_code, fp_rsp_data;
  logic [31:0] fp_alu_result = 32'd0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv32_alu_arbiter #(.PRIO_MODE(0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(rr_req0_ready), .req0_op(req0_op),
    .req0_s1(req0_s1), .req0_s2(req0_s2), .req0_pc(req0_pc), .req0_code(req0_code),
    .req1_valid(req1_valid), .req1_ready(rr_req1_ready), .req1_op(req1_op),
    .req1_s1(req1_s1), .req1_s2(req1_s2), .req1_pc(req1_pc), .req1_code(req1_code),
    .alu_enable(rr_alu_enable), .alu_opsel(rr_alu_opsel), .alu_s1(rr_alu_s1),
    .alu_s2(rr_alu_s2), .alu_pc(rr_alu_pc), .alu_code(rr_alu_code),
    .alu_result(rr_alu_result), .rsp_valid(rr_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rr_rsp_id), .rsp_data(rr_rsp_data), .flush(flush)
  );

  rv32_alu_arbiter #(.PRIO_MODE(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_op(req0_op),
    .req0_s1(req0_s1), .req0_s2(req0_s2), .req0_pc(req0_pc), .req0_code(req0_code),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_op(req1_op),
    .req1_s1(req1_s1), .req1_s2(req1_s2), .req1_pc(req1_pc), .req1_code(req1_code),
    .alu_enable(fp_alu_enable), .alu_opsel(fp_alu_opsel), .alu_s1(fp_alu_s1),
    .alu_s2(fp_alu_s2), .alu_pc(fp_alu_pc), .alu_code(fp_alu_code),
    .alu_result(fp_alu_result), .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(fp_rsp_id), .rsp_data(fp_rsp_data), .flush(flush)
  );

  // Registered ALU model: op 0 add, op 1 subtract, anything else xor.
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      default: return a ^ b;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rr_alu_enable) rr_alu_result <= alu_model(rr_alu_opsel, rr_alu_s1, rr_alu_s2);
    if (fp_alu_enable) fp_alu_result <= alu_model(fp_alu_opsel, fp_alu_s1, fp_alu_s2);
  end

  task automatic set_req(input logic n, input logic [3:0] op, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] pc, input logic [31:0] code);
    if (!n) begin
      req0_op = op; req0_s1 = s1; req0_s2 = s2; req0_pc = pc; req0_code = code;
    end else begin
      req1_op = op; req1_s1 = s1; req1_s2 = s2; req1_pc = pc; req1_code = code;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
    set_req(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    set_req(1'b1, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_cmp++; if (rr_req0_ready !== 1'b0) begin n_err++; $display("FAIL reset_req0_ready: got %b want 0", rr_req0_ready); end
    n_cmp++; if (rr_req1_ready !== 1'b0) begin n_err++; $display("FAIL reset_req1_ready: got %b want 0", rr_req1_ready); end
    n_cmp++; if (rr_alu_enable !== 1'b0) begin n_err++; $display("FAIL reset_alu_enable: got %b want 0", rr_alu_enable); end
    n_cmp++; if (rr_rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rr_rsp_valid); end
    n_cmp++; if (rr_rsp_id !== 1'b0) begin n_err++; $display("FAIL reset_rsp_id: got %b want 0", rr_rsp_id); end
    n_cmp++; if (rr_alu_opsel !== 4'd0) begin n_err++; $display("FAIL reset_alu_opsel: got %h want 0", rr_alu_opsel); end
    n_cmp++; if ({rr_alu_s1, rr_alu_s2, rr_alu_pc, rr_alu_code} !== 128'd0) begin n_err++; $display("FAIL reset_alu_operands: got %h want 0", {rr_alu_s1, rr_alu_s2, rr_alu_pc, rr_alu_code}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic       exp;
    logic [31:0] exp_data;
    set_req(1'b0, 4'd0, 32'd1,  32'd2, 32'h100, 32'h0020_8033);
    set_req(1'b1, 4'd1, 32'd10, 32'd3, 32'h200, 32'h4030_8033);
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp      = i[0];
      exp_data = exp ? 32'd7 : 32'd3;
      #1;
      n_cmp++; if (rr_req0_ready !== ~exp) begin n_err++; $display("FAIL rr_grant%0d_req0_ready: got %b want %b", i, rr_req0_ready, ~exp); end
      n_cmp++; if (rr_req1_ready !== exp) begin n_err++; $display("FAIL rr_grant%0d_req1_ready: got %b want %b", i, rr_req1_ready, exp); end
      n_cmp++; if (fp_req0_ready !== 1'b1 || fp_req1_ready !== 1'b0) begin n_err++; $display("FAIL fp_grant%0d_readies: got %b%b want 10", i, fp_req0_ready, fp_req1_ready); end
      next_cycle();
      n_cmp++; if (rr_alu_enable !== 1'b1 || rr_alu_opsel !== {3'd0, exp}) begin n_err++; $display("FAIL rr_exec%0d: got en=%b op=%h want en=1 op=%h", i, rr_alu_enable, rr_alu_opsel, {3'd0, exp}); end
      n_cmp++; if (fp_req1_ready !== 1'b0 || fp_alu_s1 !== 32'd1) begin n_err++; $display("FAIL fp_exec%0d: got rdy1=%b s1=%0d want rdy1=0 s1=1", i, fp_req1_ready, fp_alu_s1); end
      next_cycle();
      n_cmp++; if (rr_rsp_valid !== 1'b1 || rr_rsp_id !== exp || rr_rsp_data !== exp_data) begin n_err++; $display("FAIL rr_rsp%0d: got v=%b id=%b d=%0d want v=1 id=%b d=%0d", i, rr_rsp_valid, rr_rsp_id, rr_rsp_data, exp, exp_data); end
      n_cmp++; if (fp_rsp_valid !== 1'b1 || fp_rsp_id !== 1'b0 || fp_rsp_data !== 32'd3) begin n_err++; $display("FAIL fp_rsp%0d: got v=%b id=%b d=%0d want v=1 id=0 d=3", i, fp_rsp_valid, fp_rsp_id, fp_rsp_data); end
      if (i == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      next_cycle();
    end
  endtask

  task automatic test_single();
    set_req(1'b0, 4'd0, 32'd5, 32'd7, 32'h80, 32'h00b5_0533);
    req0_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    n_cmp++; if (rr_req0_ready !== 1'b1 || rr_alu_enable !== 1'b0) begin n_err++; $display("FAIL single_T: got rdy=%b en=%b want rdy=1 en=0", rr_req0_ready, rr_alu_enable); end
    next_cycle();
    req0_valid = 1'b0;
    n_cmp++; if (rr_alu_enable !== 1'b1 || rr_rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_T1: got en=%b v=%b want en=1 v=0", rr_alu_enable, rr_rsp_valid); end
    n_cmp++; if (rr_alu_s1 !== 32'd5 || rr_alu_s2 !== 32'd7 || rr_alu_pc !== 32'h80 || rr_alu_code !== 32'h00b5_0533) begin n_err++; $display("FAIL single_latch: got %h %h %h %h want 5 7 80 00b50533", rr_alu_s1, rr_alu_s2, rr_alu_pc, rr_alu_code); end
    next_cycle();
    n_cmp++; if (rr_rsp_valid !== 1'b1 || rr_rsp_id !== 1'b0 || rr_rsp_data !== 32'd12 || rr_alu_enable !== 1'b0) begin n_err++; $display("FAIL single_T2: got v=%b id=%b d=%0d en=%b want v=1 id=0 d=12 en=0", rr_rsp_valid, rr_rsp_id, rr_rsp_data, rr_alu_enable); end
    n_cmp++; if (rr_alu_s1 !== 32'd5) begin n_err++; $display("FAIL single_hold_s1: got %0d want 5", rr_alu_s1); end
    next_cycle();
    n_cmp++; if (rr_rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_done: got v=%b want 0", rr_rsp_valid); end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b0;
    set_req(1'b1, 4'd0, 32'd20, 32'd22, 32'h300, 32'h0000_0013);
    req1_valid = 1'b1;
    #1;
    n_cmp++; if (rr_req1_ready !== 1'b1) begin n_err++; $display("FAIL bp_grant: got %b want 1", rr_req1_ready); end
    next_cycle();
    req1_valid = 1'b0; req0_valid = 1'b1;
    n_cmp++; if (rr_alu_enable !== 1'b1 || rr_req0_ready !== 1'b0) begin n_err++; $display("FAIL bp_exec: got en=%b rdy0=%b want en=1 rdy0=0", rr_alu_enable, rr_req0_ready); end
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (rr_rsp_valid !== 1'b1 || rr_rsp_data !== 32'd42 || rr_rsp_id !== 1'b1) begin n_err++; $display("FAIL bp_hold%0d: got v=%b d=%0d id=%b want v=1 d=42 id=1", k, rr_rsp_valid, rr_rsp_data, rr_rsp_id); end
      n_cmp++; if (rr_alu_enable !== 1'b0 || rr_req0_ready !== 1'b0) begin n_err++; $display("FAIL bp_quiet%0d: got en=%b rdy0=%b want 0 0", k, rr_alu_enable, rr_req0_ready); end
      next_cycle();
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (rr_rsp_valid !== 1'b1 || rr_rsp_data !== 32'd42) begin n_err++; $display("FAIL bp_release: got v=%b d=%0d want v=1 d=42", rr_rsp_valid, rr_rsp_data); end
    next_cycle();
    n_cmp++; if (rr_rsp_valid !== 1'b0 || rr_req0_ready !== 1'b1) begin n_err++; $display("FAIL bp_idle: got v=%b rdy0=%b want v=0 rdy0=1", rr_rsp_valid, rr_req0_ready); end
    req0_valid = 1'b0;
    next_cycle();
  endtask

  task automatic test_flush();
    rsp_ready = 1'b1;
    set_req(1'b0, 4'd0, 32'd3, 32'd4, 32'h400, 32'h0000_0033);
    req0_valid = 1'b1; flush = 1'b1;
    #1;
    n_cmp++; if (rr_req0_ready !== 1'b0) begin n_err++; $display("FAIL flush_idle_ready: got %b want 0", rr_req0_ready); end
    next_cycle();
    flush = 1'b0;
    n_cmp++; if (rr_alu_enable !== 1'b0) begin n_err++; $display("FAIL flush_idle_nogrant: got en=%b want 0", rr_alu_enable); end
    #1;
    n_cmp++; if (rr_req0_ready !== 1'b1) begin n_err++; $display("FAIL flush_regrant: got %b want 1", rr_req0_ready); end
    next_cycle();
    req0_valid = 1'b0;
    n_cmp++; if (rr_alu_enable !== 1'b1) begin n_err++; $display("FAIL flush_exec_en: got %b want 1", rr_alu_enable); end
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    n_cmp++; if (rr_rsp_valid !== 1'b0 || rr_alu_enable !== 1'b0) begin n_err++; $display("FAIL flush_exec_abort: got v=%b en=%b want 0 0", rr_rsp_valid, rr_alu_enable); end
    set_req(1'b0, 4'd0, 32'd8, 32'd9, 32'h404, 32'h0000_0033);
    req0_valid = 1'b1;
    #1;
    n_cmp++; if (rr_req0_ready !== 1'b1) begin n_err++; $display("FAIL flush_exec_idle: got rdy0=%b want 1", rr_req0_ready); end
    next_cycle();
    req0_valid = 1'b0;
    next_cycle();
    n_cmp++; if (rr_rsp_valid !== 1'b1 || rr_rsp_data !== 32'd17) begin n_err++; $display("FAIL flush_resp_pre: got v=%b d=%0d want v=1 d=17", rr_rsp_valid, rr_rsp_data); end
    flush = 1'b1;
    #1;
    n_cmp++; if (rr_rsp_valid !== 1'b0) begin n_err++; $display("FAIL flush_resp_drop: got v=%b want 0", rr_rsp_valid); end
    next_cycle();
    flush = 1'b0;
    set_req(1'b1, 4'd1, 32'd100, 32'd1, 32'h500, 32'h4000_0033);
    req1_valid = 1'b1;
    #1;
    n_cmp++; if (rr_rsp_valid !== 1'b0 || rr_req1_ready !== 1'b1) begin n_err++; $display("FAIL flush_resp_idle: got v=%b rdy1=%b want v=0 rdy1=1", rr_rsp_valid, rr_req1_ready); end
    next_cycle();
    req1_valid = 1'b0;
    next_cycle();
    n_cmp++; if (rr_rsp_valid !== 1'b1 || rr_rsp_id !== 1'b1 || rr_rsp_data !== 32'd99) begin n_err++; $display("FAIL flush_after: got v=%b id=%b d=%0d want v=1 id=1 d=99", rr_rsp_valid, rr_rsp_id, rr_rsp_data); end
    next_cycle();
  endtask

  task automatic test_async_reset();
    rsp_ready = 1'b0;
    set_req(1'b0, 4'd0, 32'd2, 32'd2, 32'h600, 32'h0000_0033);
    req0_valid = 1'b1;
    next_cycle();
    req0_valid = 1'b0;
    next_cycle();
    n_cmp++; if (rr_rsp_valid !== 1'b1 || rr_rsp_data !== 32'd4) begin n_err++; $display("FAIL areset_pre: got v=%b d=%0d want v=1 d=4", rr_rsp_valid, rr_rsp_data); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (rr_rsp_valid !== 1'b0 || rr_alu_enable !== 1'b0 || rr_rsp_id !== 1'b0) begin n_err++; $display("FAIL areset_drop: got v=%b en=%b id=%b want 0 0 0", rr_rsp_valid, rr_alu_enable, rr_rsp_id); end
    n_cmp++; if (rr_alu_s1 !== 32'd0 || rr_alu_pc !== 32'd0) begin n_err++; $display("FAIL areset_operands: got s1=%h pc=%h want 0 0", rr_alu_s1, rr_alu_pc); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_req(1'b1, 4'd0, 32'd1, 32'd1, 32'h700, 32'h0000_0033);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_cmp++; if (rr_req0_ready !== 1'b1 || rr_req1_ready !== 1'b0) begin n_err++; $display("FAIL areset_first_grant: got %b%b want 10", rr_req0_ready, rr_req1_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
